// File: rtl/fp_addsub_pipe.sv
// Four-stage pipelined floating-point adder/subtractor with round-to-nearest-even,
// Inf/NaN handling, exception flags and a single global stall enable.
module fp_addsub_pipe #(
    parameter int unsigned EXP_W  = 5,
    parameter int unsigned FRAC_W = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        op_sub,
    input  logic [EXP_W+FRAC_W:0]       in_a,
    input  logic [EXP_W+FRAC_W:0]       in_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [EXP_W+FRAC_W:0]       out_data,
    output logic [3:0]                  out_flags
);
    localparam int unsigned W       = 1 + EXP_W + FRAC_W;
    localparam int unsigned SIG_W   = FRAC_W + 1;
    localparam int unsigned EXT_W   = FRAC_W + 4;  // hidden + frac + G,R,S
    localparam int unsigned SUM_W   = FRAC_W + 5;  // carry + EXT_W
    localparam int unsigned MR_W    = SIG_W + 1;
    localparam int unsigned LZ_W    = $clog2(SUM_W);
    localparam int unsigned XW      = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

    typedef struct packed {
        logic              sign_l;
        logic              sign_s;
        logic              eff_sub;
        logic              nan;
        logic              inf;
        logic [EXP_W-1:0]  exp_l;
        logic [EXP_W-1:0]  exp_s;
        logic [SIG_W-1:0]  sig_l;
        logic [SIG_W-1:0]  sig_s;
    } s1_t;

    typedef struct packed {
        logic              sign_l;
        logic              sign_s;
        logic              eff_sub;
        logic              nan;
        logic              inf;
        logic [EXP_W-1:0]  exp_l;
        logic [SIG_W-1:0]  sig_l;
        logic [EXT_W-1:0]  sig_s;
    } s2_t;

    typedef struct packed {
        logic              sign_l;
        logic              sign_s;
        logic              nan;
        logic              inf;
        logic [EXP_W-1:0]  exp_l;
        logic [SUM_W-1:0]  sum;
    } s3_t;

    logic en;
    logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
    logic out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [3:0]   out_flags_q, out_flags_d;
    s1_t s1_q, s1_d;
    s2_t s2_q, s2_d;
    s3_t s3_q, s3_d;

    assign en        = ~out_valid_q | out_ready;
    assign in_ready  = en & ~rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;

    assign s1_valid_d  = in_valid & in_ready;
    assign s2_valid_d  = s1_valid_q;
    assign s3_valid_d  = s2_valid_q;
    assign out_valid_d = s3_valid_q;

    // Stage 1: classify, flush subnormals, order operands by magnitude
    logic               a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
    logic [EXP_W-1:0]   a_exp, b_exp;
    logic [FRAC_W-1:0]  a_frac, b_frac;
    logic [SIG_W-1:0]   a_sig, b_sig;
    logic [W-2:0]       a_mag, b_mag;

    always_comb begin
        a_sign = in_a[W-1];
        b_sign = in_b[W-1] ^ op_sub;
        a_exp  = in_a[W-2 -: EXP_W];
        b_exp  = in_b[W-2 -: EXP_W];
        a_frac = in_a[FRAC_W-1:0];
        b_frac = in_b[FRAC_W-1:0];
        a_zero = (a_exp == '0);
        b_zero = (b_exp == '0);
        a_inf  = (a_exp == '1) && (a_frac == '0);
        b_inf  = (b_exp == '1) && (b_frac == '0);
        a_nan  = (a_exp == '1) && (a_frac != '0);
        b_nan  = (b_exp == '1) && (b_frac != '0);
        a_sig  = a_zero ? '0 : {1'b1, a_frac};
        b_sig  = b_zero ? '0 : {1'b1, b_frac};
        a_mag  = a_zero ? '0 : {a_exp, a_frac};
        b_mag  = b_zero ? '0 : {b_exp, b_frac};
        swap   = (b_mag > a_mag);

        s1_d         = '0;
        s1_d.sign_l  = swap ? b_sign : a_sign;
        s1_d.sign_s  = swap ? a_sign : b_sign;
        s1_d.exp_l   = swap ? b_exp : a_exp;
        s1_d.exp_s   = swap ? a_exp : b_exp;
        s1_d.sig_l   = swap ? b_sig : a_sig;
        s1_d.sig_s   = swap ? a_sig : b_sig;
        s1_d.eff_sub = a_sign ^ b_sign;
        s1_d.nan     = a_nan | b_nan | (a_inf & b_inf & (a_sign ^ b_sign));
        s1_d.inf     = a_inf | b_inf;
    end

    // Stage 2: align smaller significand; everything past R collapses into sticky
    logic [EXP_W-1:0]   diff;
    logic [31:0]        sh;
    logic [2*EXT_W-1:0] wide;

    always_comb begin
        diff = s1_q.exp_l - s1_q.exp_s;
        sh   = (32'(diff) > EXT_W) ? EXT_W : 32'(diff);
        wide = {s1_q.sig_s, 3'b000, {EXT_W{1'b0}}} >> sh;

        s2_d         = '0;
        s2_d.sign_l  = s1_q.sign_l;
        s2_d.sign_s  = s1_q.sign_s;
        s2_d.eff_sub = s1_q.eff_sub;
        s2_d.nan     = s1_q.nan;
        s2_d.inf     = s1_q.inf;
        s2_d.exp_l   = s1_q.exp_l;
        s2_d.sig_l   = s1_q.sig_l;
        s2_d.sig_s   = {wide[2*EXT_W-1 -: EXT_W-1], wide[EXT_W] | (|wide[EXT_W-1:0])};
    end

    // Stage 3: magnitude add/sub; operand order makes the difference non-negative
    logic [SUM_W-1:0] op_l, op_s;

    always_comb begin
        op_l        = {1'b0, s2_q.sig_l, 3'b000};
        op_s        = {1'b0, s2_q.sig_s};
        s3_d        = '0;
        s3_d.sign_l = s2_q.sign_l;
        s3_d.sign_s = s2_q.sign_s;
        s3_d.nan    = s2_q.nan;
        s3_d.inf    = s2_q.inf;
        s3_d.exp_l  = s2_q.exp_l;
        s3_d.sum    = s2_q.eff_sub ? (op_l - op_s) : (op_l + op_s);
    end

    // Stage 4: normalise, round to nearest even, pack and apply exceptions
    logic [LZ_W-1:0]   lzc;
    logic              found, rnd_inc, rnd_carry, inexact;
    logic [EXT_W-1:0]  norm;
    logic [MR_W-1:0]   mant_r;
    logic [FRAC_W-1:0] frac_r;
    logic signed [XW-1:0] exp_n, exp_r;

    always_comb begin
        lzc   = '0;
        found = 1'b0;
        for (int i = SUM_W - 2; i >= 0; i--) begin
            if (!found) begin
                if (s3_q.sum[i]) found = 1'b1;
                else             lzc   = lzc + 1'b1;
            end
        end

        if (s3_q.sum[SUM_W-1]) begin
            norm  = {s3_q.sum[SUM_W-1:2], s3_q.sum[1] | s3_q.sum[0]};
            exp_n = $signed(XW'(s3_q.exp_l)) + $signed(XW'(1));
        end else begin
            norm  = s3_q.sum[EXT_W-1:0] << lzc;
            exp_n = $signed(XW'(s3_q.exp_l)) - $signed(XW'(lzc));
        end

        inexact   = |norm[2:0];
        rnd_inc   = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r    = {1'b0, norm[EXT_W-1:3]} + MR_W'(rnd_inc);
        rnd_carry = mant_r[MR_W-1];
        frac_r    = rnd_carry ? mant_r[FRAC_W:1] : mant_r[FRAC_W-1:0];
        exp_r     = exp_n + $signed(XW'(rnd_carry));

        out_data_d  = {s3_q.sign_l, exp_r[EXP_W-1:0], frac_r};
        out_flags_d = {3'b000, inexact};
        if (s3_q.nan) begin
            out_data_d  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
            out_flags_d = 4'b1000;
        end else if (s3_q.inf) begin
            out_data_d  = {s3_q.sign_l, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            out_flags_d = 4'b0000;
        end else if (s3_q.sum == '0) begin
            out_data_d  = {s3_q.sign_l & s3_q.sign_s, {(W-1){1'b0}}};
            out_flags_d = 4'b0000;
        end else if (exp_r >= $signed(XW'(EXP_MAX))) begin
            out_data_d  = {s3_q.sign_l, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            out_flags_d = 4'b0101;
        end else if (exp_n <= $signed(XW'(0))) begin
            out_data_d  = {s3_q.sign_l, {(W-1){1'b0}}};
            out_flags_d = 4'b0011;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else if (en) begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            s3_valid_q  <= s3_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe (fp16 configuration): directed vectors, a stalled
// burst, and a mid-burst reset.
module tb_fp_addsub_pipe;
    localparam int NV = 13;

    logic        clk, rst, in_valid, in_ready, op_sub, out_valid, out_ready;
    logic [15:0] in_a, in_b, out_data;
    logic [3:0]  out_flags;

    fp_addsub_pipe #(.EXP_W(5), .FRAC_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    // Hand-computed fp16 vectors: a, b, op_sub -> data, {invalid, overflow, underflow, inexact}
    logic [15:0] va [NV] = '{16'h3C00, 16'h3C00, 16'h8000, 16'h3C00, 16'h3C01, 16'h7BFF,
                             16'h7C00, 16'h7E00, 16'h0400, 16'h0401, 16'h4000, 16'h3C00,
                             16'hC000};
    logic [15:0] vb [NV] = '{16'h3C00, 16'h3C00, 16'h8000, 16'h1000, 16'h1000, 16'h7BFF,
                             16'hFC00, 16'h3C00, 16'h03FF, 16'h0400, 16'h3C00, 16'hC000,
                             16'h3C00};
    logic        vs [NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                             1'b1, 1'b0, 1'b1};
    logic [15:0] vd [NV] = '{16'h4000, 16'h0000, 16'h8000, 16'h3C00, 16'h3C02, 16'h7C00,
                             16'h7E00, 16'h7E00, 16'h0400, 16'h0000, 16'h3C00, 16'hBC00,
                             16'hC200};
    logic [3:0]  vf [NV] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0101,
                             4'b1000, 4'b1000, 4'b0000, 4'b0011, 4'b0000, 4'b0000,
                             4'b0000};

    typedef struct {
        logic [15:0] d;
        logic [3:0]  f;
        int          acc;
        bit          lat;
        int          idx;
    } item_t;

    item_t sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    burst_start = 0;
    bit    stall_en = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish within bound");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Out_ready is pulled low on burst-relative cycles 6..8
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_en)
                out_ready = !(((cyc - burst_start) >= 6) && ((cyc - burst_start) <= 8));
        end
    end

    // Monitor: pops on every accepted output and checks hold during stalls
    initial begin
        item_t       it;
        bit          held_valid = 1'b0;
        logic [15:0] held_data;
        logic [3:0]  held_flags;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (held_valid) begin
                    chk("stall_hold_data", 32'(out_data), 32'(held_data));
                    chk("stall_hold_flags", 32'(out_flags), 32'(held_flags));
                end
                if (out_ready) begin
                    held_valid = 1'b0;
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got data 0x%0h, expected no output",
                                 out_data);
                    end else begin
                        it = sb_q.pop_front();
                        chk($sformatf("data_v%0d", it.idx), 32'(out_data), 32'(it.d));
                        chk($sformatf("flags_v%0d", it.idx), 32'(out_flags), 32'(it.f));
                        if (it.lat)
                            chk($sformatf("latency_v%0d", it.idx), 32'(cyc - it.acc), 32'd4);
                    end
                end else begin
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    held_valid = 1'b1;
                    held_data  = out_data;
                    held_flags = out_flags;
                end
            end else begin
                held_valid = 1'b0;
            end
        end
    end

    // Called in the post-posedge phase; returns in the same phase
    task automatic drive_one(input int idx, input bit lat);
        item_t it;
        int    guard = 0;
        in_valid = 1'b1;
        in_a     = va[idx];
        in_b     = vb[idx];
        op_sub   = vs[idx];
        forever begin
            @(negedge clk);
            if (in_ready) begin
                it.d = vd[idx]; it.f = vf[idx]; it.acc = cyc; it.lat = lat; it.idx = idx;
                sb_q.push_back(it);
                @(posedge clk);
                #1;
                break;
            end
            guard++;
            if (guard > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout_v%0d: got in_ready 0, expected 1", idx);
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb_q.size());
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        op_sub    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_flags", 32'(out_flags), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Isolated transactions with latency checks
        for (int i = 0; i < NV; i++) begin
            drive_one(i, 1'b1);
            wait_drain();
        end

        // Back-to-back burst with a three-cycle downstream stall
        burst_start = cyc;
        stall_en    = 1'b1;
        for (int i = 0; i < NV; i++) drive_one(i, 1'b0);
        wait_drain();
        stall_en  = 1'b0;
        out_ready = 1'b1;

        // Reset in the middle of a burst
        for (int i = 0; i < 6; i++) drive_one(i, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;

        // Recovery after reset
        drive_one(0, 1'b1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
